// File: rtl/barrett_reduce_8380417_pkg.sv
// Shared constants and helpers for Barrett reduction modulo the Dilithium prime q = 8380417.
// The correction helper turns the raw (qest, r) estimate into the exact quotient/remainder.
package barrett_reduce_8380417_pkg;

    localparam int X_W       = 46;
    localparam int Q_W       = 24;
    localparam int R_W       = 23;
    localparam int BARRETT_K = 46;
    localparam int PROD_W    = X_W + Q_W;
    localparam int QQ_W      = 48;
    localparam int RC_W      = 26;

    localparam logic [Q_W-1:0] DIL_Q     = 24'd8380417;
    localparam logic [Q_W-1:0] BARRETT_M = 24'd8396807;

    typedef struct packed {
        logic [Q_W-1:0] quotient;
        logic [R_W-1:0] remainder;
    } barrett_res_t;

    // qest trails floor(x/q) by at most 2, so two conditional subtractions always suffice.
    function automatic barrett_res_t barrett_correct(input logic [RC_W-1:0] r,
                                                     input logic [Q_W-1:0]  qest);
        logic [RC_W-1:0] r_v;
        logic [Q_W-1:0]  q_v;
        barrett_res_t    res;
        r_v = r;
        q_v = qest;
        for (int i = 0; i < 2; i++) begin
            if (r_v >= {2'd0, DIL_Q}) begin
                r_v = r_v - {2'd0, DIL_Q};
                q_v = q_v + 24'd1;
            end else begin
                r_v = r_v;
                q_v = q_v;
            end
        end
        res.quotient  = q_v;
        res.remainder = R_W'(r_v);
        return res;
    endfunction

endpackage

// File: rtl/barrett_reduce_8380417.sv
// Three-stage pipelined Barrett reducer for q = 8380417: returns floor(x/q) and x mod q
// for any 46-bit x, one operand per clock, no backpressure.
module barrett_reduce_8380417
    import barrett_reduce_8380417_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    output logic             io_in_ready,
    input  logic             io_in_valid,
    input  logic [X_W-1:0]   io_in_bits,
    input  logic             io_out_ready,
    output logic             io_out_valid,
    output logic [R_W-1:0]   io_out_bits_remainder,
    output logic [Q_W-1:0]   io_out_bits_quotient
);

    logic [X_W-1:0]    x_s1_r;
    logic              v_s1_r;
    logic [X_W-1:0]    x_s2_r;
    logic [Q_W-1:0]    qest_s2_r;
    logic              v_s2_r;
    logic              out_valid_r;
    logic [Q_W-1:0]    out_quot_r;
    logic [R_W-1:0]    out_rem_r;

    logic [PROD_W-1:0] prod_s;
    logic [Q_W-1:0]    qest_s;
    logic [QQ_W-1:0]   qe_w_s;
    logic [QQ_W-1:0]   qq_s;
    logic [QQ_W-1:0]   r_wide_s;
    logic [RC_W-1:0]   r_s;
    barrett_res_t      res_s;
    logic              unused_out_ready_s;

    // No backpressure: the consumer's ready is intentionally ignored.
    assign unused_out_ready_s = io_out_ready;
    assign io_in_ready        = reset;

    // Stage 2 arithmetic: high part of the full-width x*m product.
    always_comb begin
        prod_s = {24'd0, x_s1_r} * {46'd0, BARRETT_M};
        qest_s = Q_W'(prod_s >> BARRETT_K);
    end

    // Stage 3 arithmetic: r = x - qest*q with q = 2^23 - 2^13 + 1, then exact correction.
    always_comb begin
        qe_w_s   = {24'd0, qest_s2_r};
        qq_s     = (qe_w_s << 6'd23) - (qe_w_s << 6'd13) + qe_w_s;
        r_wide_s = {2'd0, x_s2_r} - qq_s;
        r_s      = RC_W'(r_wide_s);
        res_s    = barrett_correct(r_s, qest_s2_r);
    end

    // Pipeline and output registers; data always loads so invalid slots stay defined.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_s1_r      <= 46'd0;
            v_s1_r      <= 1'b0;
            x_s2_r      <= 46'd0;
            qest_s2_r   <= 24'd0;
            v_s2_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_quot_r  <= 24'd0;
            out_rem_r   <= 23'd0;
        end else begin
            x_s1_r      <= io_in_bits;
            v_s1_r      <= io_in_valid;
            x_s2_r      <= x_s1_r;
            qest_s2_r   <= qest_s;
            v_s2_r      <= v_s1_r;
            out_valid_r <= v_s2_r;
            out_quot_r  <= res_s.quotient;
            out_rem_r   <= res_s.remainder;
        end
    end

    assign io_out_valid          = out_valid_r;
    assign io_out_bits_quotient  = out_quot_r;
    assign io_out_bits_remainder = out_rem_r;

endmodule

// File: tb/tb_barrett_reduce_8380417.sv
// Directed bench for barrett_reduce_8380417: hand-computed vectors, valid timing,
// async reset mid-stream, plus a short random run against a division-based model.
module tb_barrett_reduce_8380417;

    localparam longint Q = 64'd8380417;

    logic        clock;
    logic        reset;
    logic        io_in_ready;
    logic        io_in_valid;
    logic [45:0] io_in_bits;
    logic        io_out_ready;
    logic        io_out_valid;
    logic [22:0] io_out_bits_remainder;
    logic [23:0] io_out_bits_quotient;

    int n_assert = 0;
    int n_fail   = 0;

    barrett_reduce_8380417 dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_in_ready           (io_in_ready),
        .io_in_valid           (io_in_valid),
        .io_in_bits            (io_in_bits),
        .io_out_ready          (io_out_ready),
        .io_out_valid          (io_out_valid),
        .io_out_bits_remainder (io_out_bits_remainder),
        .io_out_bits_quotient  (io_out_bits_quotient)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic exp_v, input longint exp_q, input longint exp_r);
        chk_bit({tag, "_valid"}, io_out_valid, exp_v);
        n_assert++;
        assert ({40'd0, io_out_bits_quotient} === exp_q[63:0]) else begin
            n_fail++;
            $error("FAIL %s_quot: observed %0d expected %0d", tag, io_out_bits_quotient, exp_q);
        end
        n_assert++;
        assert ({41'd0, io_out_bits_remainder} === exp_r[63:0]) else begin
            n_fail++;
            $error("FAIL %s_rem: observed %0d expected %0d", tag, io_out_bits_remainder, exp_r);
        end
    endtask

    logic [63:0] rnd;
    logic [45:0] xs  [0:63];
    logic        vs  [0:63];
    logic        pat [0:4];

    initial begin
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_in_bits   = 46'd0;
        io_out_ready = 1'b0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;

        // Reset state
        #3;
        chk_res("reset", 1'b0, 0, 0);
        chk_bit("in_ready_rst", io_in_ready, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk_bit("in_ready_run", io_in_ready, 1'b1);

        // Back-to-back 0, q-1, q
        io_in_valid = 1'b1; io_in_bits = 46'd0;       tick();
        io_in_bits = 46'd8380416;                      tick();
        io_in_bits = 46'd8380417;                      tick();
        chk_res("x0", 1'b1, 0, 0);
        io_in_valid = 1'b0; io_in_bits = 46'd0;        tick();
        chk_res("xqm1", 1'b1, 0, 8380416);
        tick();
        chk_res("xq", 1'b1, 1, 0);
        tick();
        chk_res("bubble", 1'b0, 0, 0);

        // (q-1)^2
        io_in_valid = 1'b1; io_in_bits = 46'd70231372333056;
        tick(); tick(); tick();
        chk_res("sq_qm1", 1'b1, 8380415, 1);
        // q^2
        io_in_bits = 46'd70231389093889;
        tick(); tick(); tick();
        chk_res("sq_q", 1'b1, 8380417, 0);
        // 2^46-1, maximum correction path
        io_in_bits = 46'h3FFF_FFFF_FFFF;
        tick(); tick(); tick();
        chk_res("xmax", 1'b1, 8396807, 49144);
        // Mid-range value
        io_in_bits = 46'd12345678;
        tick(); tick(); tick();
        chk_res("mid", 1'b1, 1, 3965261);

        // Valid pattern 1,0,1,1,0 with io_out_ready held low
        io_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                io_in_valid = pat[i];
                io_in_bits  = 46'(5 + i);
            end else begin
                io_in_valid = 1'b0;
                io_in_bits  = 46'd0;
            end
            tick();
            if (i >= 2) begin
                if (i - 2 < 5) chk_res($sformatf("pat%0d", i - 2), pat[i - 2], 0, longint'(5 + i - 2));
                else           chk_res($sformatf("pat%0d", i - 2), 1'b0, 0, 0);
            end
        end

        // Async reset with three operands in flight
        io_in_valid = 1'b1;
        io_in_bits = 46'd100; tick();
        io_in_bits = 46'd200; tick();
        io_in_bits = 46'd300; tick();
        #2;
        reset = 1'b0;
        #1;
        chk_res("async_rst", 1'b0, 0, 0);
        chk_bit("in_ready_async", io_in_ready, 1'b0);
        io_in_valid = 1'b0; io_in_bits = 46'd0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_bit($sformatf("no_stale%0d", i), io_out_valid, 1'b0);
        end
        io_in_valid = 1'b1; io_in_bits = 46'(Q + 5);
        tick();
        io_in_valid = 1'b0; io_in_bits = 46'd0;
        tick(); tick();
        chk_res("post_rst", 1'b1, 1, 5);

        // Random stream against a division model
        for (int i = 0; i < 64; i++) begin
            rnd   = {$urandom(), $urandom()};
            xs[i] = rnd[45:0];
            vs[i] = rnd[63];
        end
        for (int i = 0; i < 66; i++) begin
            if (i < 64) begin
                io_in_valid = vs[i];
                io_in_bits  = xs[i];
            end else begin
                io_in_valid = 1'b0;
                io_in_bits  = 46'd0;
            end
            tick();
            if (i >= 2) begin
                chk_res($sformatf("rnd%0d", i - 2), vs[i - 2],
                        longint'({18'd0, xs[i - 2]}) / Q,
                        longint'({18'd0, xs[i - 2]}) % Q);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
